// File: rtl/div16_seq.sv
// div16_seq: multi-cycle unsigned restoring divider.
//
// Produces one quotient bit per clock by trial subtraction of the divisor
// from a shifted partial remainder. The ALU starts a divide with `start` and
// picks up the result on the one-cycle `done` pulse.
//
// Ports:
//   clk          system clock; all state changes on the rising edge
//   reset        synchronous, active-high; discards any divide in flight
//   start        request a divide; only honoured while busy=0
//   dividend     numerator, captured on the accepting edge only
//   divisor      denominator, captured on the accepting edge only
//   busy         high from the accepting edge until the cycle after done
//   done         one-cycle pulse; quotient/remainder/div_by_zero are final
//   quotient     floor(dividend / divisor); all ones on divide by zero
//   remainder    dividend mod divisor; the dividend on divide by zero
//   div_by_zero  set together with done when the divisor was zero
//
// Timing (WIDTH=16): accept at edge E0, iterations on E1..E16, done=1 in
// the cycle after E16, back to idle at E17. A zero divisor skips the
// iterations and signals done in the cycle right after E0.

module div16_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // One restoring step. The trial value is WIDTH+1 bits wide because the
    // partial remainder may already use its top bit (e.g. divisor 0xFFFF)
    // before the next dividend bit is shifted in. Returns {qbit, new_rem}.
    // Either branch fits in WIDTH bits: T-V < V and, when T < V, T < V.
    function automatic logic [WIDTH:0] restore_step(
        input logic [WIDTH-1:0] rem,
        input logic             next_bit,
        input logic [WIDTH-1:0] den
    );
        logic [WIDTH:0] trial;
        logic [WIDTH:0] diff;
        trial = {rem, next_bit};
        diff  = trial - {1'b0, den};
        if (trial >= {1'b0, den}) begin
            restore_step = {1'b1, diff[WIDTH-1:0]};
        end else begin
            restore_step = {1'b0, trial[WIDTH-1:0]};
        end
    endfunction

    logic [1:0]       state_r;
    logic [WIDTH-1:0] d_r;       // dividend shift register, MSB consumed first
    logic [WIDTH-1:0] v_r;       // captured divisor
    logic [WIDTH-1:0] r_r;       // partial remainder
    logic [WIDTH-1:0] q_r;       // quotient, bits enter at the LSB
    logic [CNT_W-1:0] cnt_r;
    logic             busy_r;
    logic             done_r;
    logic             dbz_r;

    logic [WIDTH:0]   step_s;
    logic             qbit_s;
    logic [WIDTH-1:0] rem_next_s;
    logic             last_iter_s;
    logic             accept_s;

    // Trial subtraction for the current iteration and handshake decodes.
    always_comb begin
        step_s      = restore_step(r_r, d_r[WIDTH-1], v_r);
        qbit_s      = step_s[WIDTH];
        rem_next_s  = step_s[WIDTH-1:0];
        last_iter_s = (cnt_r == CNT_LAST);
        if (state_r == ST_IDLE) begin
            accept_s = start;
        end else begin
            accept_s = 1'b0;
        end
    end

    // Control FSM and datapath registers; reset wins over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            d_r     <= {WIDTH{1'b0}};
            v_r     <= {WIDTH{1'b0}};
            r_r     <= {WIDTH{1'b0}};
            q_r     <= {WIDTH{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            dbz_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        d_r    <= dividend;
                        v_r    <= divisor;
                        cnt_r  <= {CNT_W{1'b0}};
                        busy_r <= 1'b1;
                        if (divisor == {WIDTH{1'b0}}) begin
                            // No iterations: present the saturated result now
                            // so it is ready on the done cycle.
                            state_r <= ST_DONE;
                            q_r     <= {WIDTH{1'b1}};
                            r_r     <= dividend;
                            dbz_r   <= 1'b1;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= ST_RUN;
                            q_r     <= {WIDTH{1'b0}};
                            r_r     <= {WIDTH{1'b0}};
                            dbz_r   <= 1'b0;
                            done_r  <= 1'b0;
                        end
                    end else begin
                        // Results from the last divide stay visible.
                        busy_r <= 1'b0;
                        done_r <= 1'b0;
                    end
                end

                ST_RUN: begin
                    r_r   <= rem_next_s;
                    q_r   <= {q_r[WIDTH-2:0], qbit_s};
                    d_r   <= {d_r[WIDTH-2:0], 1'b0};
                    cnt_r <= cnt_r + CNT_ONE;
                    if (last_iter_s) begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= ST_RUN;
                        done_r  <= 1'b0;
                    end
                    busy_r <= 1'b1;
                end

                ST_DONE: begin
                    // start is ignored here; the next request needs IDLE.
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end

                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        busy        = busy_r;
        done        = done_r;
        quotient    = q_r;
        remainder   = r_r;
        div_by_zero = dbz_r;
    end

endmodule

// File: tb/tb_div16_seq.sv
// Self-checking bench for div16_seq: the driver pushes the expected result
// of every accepted divide into a queue; an independent monitor pops and
// compares on each done pulse.

module tb_div16_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;

    typedef struct packed {
        logic [15:0] q;
        logic [15:0] r;
        logic        dbz;
    } res_t;

    res_t exp_q[$];
    res_t mon_exp;
    res_t mon_got;
    int   n_cmp    = 0;
    int   n_bad    = 0;
    int   n_accept = 0;
    int   n_done   = 0;

    div16_seq #(.WIDTH(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic res_t mk(input logic [15:0] q, input logic [15:0] r, input logic dbz);
        res_t x;
        x.q = q; x.r = r; x.dbz = dbz;
        return x;
    endfunction

    // Arithmetic reference for the sweep.
    function automatic res_t model(input logic [15:0] a, input logic [15:0] b);
        if (b == 16'd0) return mk(16'hFFFF, a, 1'b1);
        return mk(a / b, a % b, 1'b0);
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            n_done++;
            n_cmp++;
            mon_got = mk(quotient, remainder, div_by_zero);
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_done: got q=%0h r=%0h dbz=%0b expected no done",
                         quotient, remainder, div_by_zero);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp) begin
                    n_bad++;
                    $display("FAIL result: got q=%0h r=%0h dbz=%0b expected q=%0h r=%0h dbz=%0b",
                             mon_got.q, mon_got.r, mon_got.dbz, mon_exp.q, mon_exp.r, mon_exp.dbz);
                end
            end
        end
    end

    // One divide with latency/busy checks. With poke set, start is pulsed
    // with 9/9 mid-run and again on the done cycle; both must be ignored.
    task automatic run_div(input logic [15:0] a, input logic [15:0] b,
                           input res_t exp, input bit poke);
        int lat;
        int exp_lat;
        exp_lat = (b == 16'd0) ? 0 : 16;
        @(negedge clk);
        dividend = a; divisor = b; start = 1'b1;
        exp_q.push_back(exp);
        n_accept++;
        @(posedge clk); #1;
        start = 1'b0;
        dividend = 16'($urandom);
        divisor  = 16'($urandom);
        chk("busy_after_accept", 32'(busy), 32'd1);
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (poke && lat == 4) begin
                start = 1'b1; dividend = 16'd9; divisor = 16'd9;
            end
            @(posedge clk); #1;
            start = 1'b0;
            lat++;
        end
        chk("done_latency", 32'(lat), 32'(exp_lat));
        chk("busy_on_done", 32'(busy), 32'd1);
        if (poke) begin
            start = 1'b1; dividend = 16'd9; divisor = 16'd9;
        end
        @(posedge clk); #1;
        start = 1'b0;
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("busy_fall", 32'(busy), 32'd0);
    endtask

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 7))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'($urandom_range(1, 15));
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        logic [15:0] a;
        logic [15:0] b;
        reset = 1'b1; start = 1'b0; dividend = 16'd0; divisor = 16'd0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_q", 32'(quotient), 32'd0);
        chk("reset_r", 32'(remainder), 32'd0);
        chk("reset_dbz", 32'(div_by_zero), 32'd0);

        // Basic divide, then result must hold while idle.
        run_div(16'd100, 16'd7, mk(16'd14, 16'd2, 1'b0), 1'b0);
        repeat (3) @(negedge clk);
        chk("hold_q", 32'(quotient), 32'd14);
        chk("hold_r", 32'(remainder), 32'd2);
        chk("hold_dbz", 32'(div_by_zero), 32'd0);

        // Extremes.
        run_div(16'hFFFF, 16'd1,    mk(16'hFFFF, 16'd0, 1'b0), 1'b0);
        run_div(16'hFFFF, 16'hFFFF, mk(16'd1,    16'd0, 1'b0), 1'b0);
        run_div(16'd5,    16'd9,    mk(16'd0,    16'd5, 1'b0), 1'b0);
        run_div(16'd0,    16'd5,    mk(16'd0,    16'd0, 1'b0), 1'b0);
        run_div(16'h8000, 16'hC000, mk(16'd0, 16'h8000, 1'b0), 1'b0);
        run_div(16'hFFFE, 16'h8001, mk(16'd1, 16'h7FFD, 1'b0), 1'b0);

        // Divide by zero.
        run_div(16'd1234, 16'd0, mk(16'hFFFF, 16'd1234, 1'b1), 1'b0);

        // Ignored starts while busy, then back-to-back from the first idle cycle.
        run_div(16'd40, 16'd3, mk(16'd13, 16'd1, 1'b0), 1'b1);
        chk("ignored_q", 32'(quotient), 32'd13);
        chk("ignored_r", 32'(remainder), 32'd1);
        run_div(16'd9, 16'd9, mk(16'd1, 16'd0, 1'b0), 1'b0);

        // Abort mid-run with reset; the aborted divide must never signal done.
        @(negedge clk);
        dividend = 16'd1000; divisor = 16'd10; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_q", 32'(quotient), 32'd0);
        chk("abort_r", 32'(remainder), 32'd0);
        chk("abort_dbz", 32'(div_by_zero), 32'd0);
        repeat (20) @(posedge clk);
        run_div(16'd1000, 16'd10, mk(16'd100, 16'd0, 1'b0), 1'b0);

        // Sweep against the arithmetic reference.
        for (int i = 0; i < 2000; i++) begin
            a = pick();
            b = pick();
            run_div(a, b, model(a, b), 1'b0);
        end

        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        chk("done_count", 32'(n_done), 32'(n_accept));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
